// File: rtl/mining_pkg.sv
// -----------------------------------------------------------------------------
// mining_pkg
// Shared constants and types for the miner work-loading path.
//   MID_WORDS   : 32-bit midstate words per job
//   TAIL_WORDS  : 32-bit block-tail words per job (merkle tail, time, bits)
//   JOB_WORDS   : total words per job on the input stream
//   job_idx_t   : index of a word within a job (0 .. JOB_WORDS-1)
//   state_t     : loader FSM state encoding (ST_FILL / ST_PENDING / ST_DROP)
// -----------------------------------------------------------------------------
package mining_pkg;

    localparam int MID_WORDS  = 8;
    localparam int TAIL_WORDS = 3;
    localparam int JOB_WORDS  = MID_WORDS + TAIL_WORDS;

    // Word index encoding: 0..MID_WORDS-1 address the midstate,
    // MID_WORDS..JOB_WORDS-1 address the block tail.
    localparam int IDX_W = 4;
    typedef logic [IDX_W-1:0] job_idx_t;

    typedef logic [1:0] state_t;
    localparam state_t ST_FILL    = 2'd0;
    localparam state_t ST_PENDING = 2'd1;
    localparam state_t ST_DROP    = 2'd2;

endpackage

// File: rtl/job_shadow_buf.sv
// -----------------------------------------------------------------------------
// job_shadow_buf
// Indexed 32-bit word writer that assembles the next job while the active job
// keeps running. Word index k < N_MID lands in the midstate vector at
// [32k +: 32]; the remaining indices land in the tail vector at
// [32(k-N_MID) +: 32].
// Ports:
//   clk          : clock
//   rst          : synchronous active-high reset, clears both vectors
//   wr_en_i      : write strobe (one accepted job word)
//   wr_idx_i     : word index within the job
//   wr_data_i    : word value
//   shadow_mid_o : assembled midstate, 32*N_MID bits
//   shadow_tail_o: assembled block tail, 32*N_TAIL bits
// -----------------------------------------------------------------------------
module job_shadow_buf #(
    parameter int N_MID  = 8,
    parameter int N_TAIL = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [3:0]            wr_idx_i,
    input  logic [31:0]           wr_data_i,
    output logic [32*N_MID-1:0]   shadow_mid_o,
    output logic [32*N_TAIL-1:0]  shadow_tail_o
);

    logic [32*N_MID-1:0]  mid_q;
    logic [32*N_TAIL-1:0] tail_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mid_q  <= '0;
            tail_q <= '0;
        end else if (wr_en_i) begin
            for (int w = 0; w < N_MID; w++) begin
                if (wr_idx_i == 4'(w)) begin
                    mid_q[32*w +: 32] <= wr_data_i;
                end
            end
            for (int w = 0; w < N_TAIL; w++) begin
                if (wr_idx_i == 4'(N_MID + w)) begin
                    tail_q[32*w +: 32] <= wr_data_i;
                end
            end
        end
    end

    assign shadow_mid_o  = mid_q;
    assign shadow_tail_o = tail_q;

endmodule

// File: rtl/sha256_work_loader.sv
// -----------------------------------------------------------------------------
// sha256_work_loader
// Upstream feeder for the miner. Collects a job (midstate + block tail) from a
// 32-bit valid/ready word stream into a shadow buffer, then swaps it into the
// active job registers on the next hash-pipeline load boundary (load_ok).
// The swap raises nonce_clear for one cycle so the miner restarts at nonce 0.
//
// State table:
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_FILL    | accepting job words into the shadow buffer
//   ST_PENDING | complete job waiting for load_ok; input stalled
//   ST_DROP    | overlong job: discarding words until in_last
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   in_valid/ready : word-stream handshake
//   in_data        : job word
//   in_last        : final word of a job
//   load_ok        : miner boundary strobe (next nonce counter value is 0)
//   midstate_out   : active midstate
//   tail_out       : active block tail
//   work_valid     : a job has been loaded since reset
//   work_id        : swap counter, wraps modulo 2^ID_W
//   nonce_clear    : one-cycle pulse, coincident with new active outputs
//   err_short      : sticky, in_last arrived early
//   err_long       : sticky, final word arrived without in_last
// -----------------------------------------------------------------------------
module sha256_work_loader #(
    parameter int MID_WORDS  = 8,
    parameter int TAIL_WORDS = 3,
    parameter int ID_W       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_data,
    input  logic                      in_last,
    input  logic                      load_ok,
    output logic [32*MID_WORDS-1:0]   midstate_out,
    output logic [32*TAIL_WORDS-1:0]  tail_out,
    output logic                      work_valid,
    output logic [ID_W-1:0]           work_id,
    output logic                      nonce_clear,
    output logic                      err_short,
    output logic                      err_long
);

    import mining_pkg::*;

    localparam job_idx_t LAST_IDX = job_idx_t'(MID_WORDS + TAIL_WORDS - 1);

    state_t   state_q, state_d;
    job_idx_t k_q, k_d;
    logic     err_short_q, err_short_d;
    logic     err_long_q, err_long_d;

    logic [32*MID_WORDS-1:0]  mid_q;
    logic [32*TAIL_WORDS-1:0] tail_q;
    logic                     work_valid_q;
    logic [ID_W-1:0]          work_id_q;
    logic                     nonce_clear_q;

    logic [32*MID_WORDS-1:0]  shadow_mid;
    logic [32*TAIL_WORDS-1:0] shadow_tail;

    logic accept;
    logic shadow_wr;
    logic swap;

    // Ready drops combinationally under reset so nothing is taken while the
    // registers are being cleared.
    assign in_ready  = !rst && (state_q != ST_PENDING);
    assign accept    = in_valid && in_ready;
    assign shadow_wr = accept && (state_q == ST_FILL);
    assign swap      = (state_q == ST_PENDING) && load_ok;

    job_shadow_buf #(
        .N_MID  (MID_WORDS),
        .N_TAIL (TAIL_WORDS)
    ) u_shadow (
        .clk           (clk),
        .rst           (rst),
        .wr_en_i       (shadow_wr),
        .wr_idx_i      (k_q),
        .wr_data_i     (in_data),
        .shadow_mid_o  (shadow_mid),
        .shadow_tail_o (shadow_tail)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        err_short_d = err_short_q;
        err_long_d  = err_long_q;
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    if (in_last) begin
                        k_d = '0;
                        if (k_q == LAST_IDX) begin
                            state_d = ST_PENDING;
                        end else begin
                            // Partial job is abandoned; the next job overwrites
                            // every shadow word before it can be swapped in.
                            err_short_d = 1'b1;
                        end
                    end else if (k_q == LAST_IDX) begin
                        k_d        = '0;
                        err_long_d = 1'b1;
                        state_d    = ST_DROP;
                    end else begin
                        k_d = k_q + job_idx_t'(1);
                    end
                end
            end
            ST_DROP: begin
                if (accept && in_last) begin
                    state_d = ST_FILL;
                end
            end
            ST_PENDING: begin
                if (load_ok) begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
                k_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            k_q         <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    // Active job registers; nonce_clear is registered alongside so it rises in
    // the same cycle the new job becomes visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            mid_q         <= '0;
            tail_q        <= '0;
            work_valid_q  <= 1'b0;
            work_id_q     <= '0;
            nonce_clear_q <= 1'b0;
        end else begin
            nonce_clear_q <= swap;
            if (swap) begin
                mid_q        <= shadow_mid;
                tail_q       <= shadow_tail;
                work_valid_q <= 1'b1;
                work_id_q    <= work_id_q + ID_W'(1);
            end
        end
    end

    assign midstate_out = mid_q;
    assign tail_out     = tail_q;
    assign work_valid   = work_valid_q;
    assign work_id      = work_id_q;
    assign nonce_clear  = nonce_clear_q;
    assign err_short    = err_short_q;
    assign err_long     = err_long_q;

endmodule

// File: tb/tb_sha256_work_loader.sv
module tb_sha256_work_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic         load_ok;
    logic [255:0] midstate_out;
    logic [95:0]  tail_out;
    logic         work_valid;
    logic [3:0]   work_id;
    logic         nonce_clear;
    logic         err_short;
    logic         err_long;

    int checks   = 0;
    int failures = 0;

    logic [255:0] exp_mid;
    logic [95:0]  exp_tail;
    logic [3:0]   exp_id;
    logic         exp_valid;

    typedef struct {
        logic [31:0] base;
        int          gap;
        logic [3:0]  exp_id;
    } job_vec_t;

    job_vec_t vecs [3];

    always #5 clk = ~clk;

    sha256_work_loader #(
        .MID_WORDS  (8),
        .TAIL_WORDS (3),
        .ID_W       (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .load_ok      (load_ok),
        .midstate_out (midstate_out),
        .tail_out     (tail_out),
        .work_valid   (work_valid),
        .work_id      (work_id),
        .nonce_clear  (nonce_clear),
        .err_short    (err_short),
        .err_long     (err_long)
    );

    function automatic logic [255:0] mid_of(input logic [31:0] b);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = b + 32'(i);
        return r;
    endfunction

    function automatic logic [95:0] tail_of(input logic [31:0] b);
        logic [95:0] r;
        for (int i = 0; i < 3; i++) r[32*i +: 32] = b + 32'(8 + i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_active(input string tag);
        chk({tag, ".midstate_out"}, midstate_out, exp_mid);
        chk({tag, ".tail_out"}, 256'(tail_out), 256'(exp_tail));
        chk({tag, ".work_id"}, 256'(work_id), 256'(exp_id));
        chk({tag, ".work_valid"}, 256'(work_valid), 256'(exp_valid));
    endtask

    // Called at a negedge; returns at the negedge after the last word's posedge.
    task automatic stream(input logic [31:0] base, input int n, input int last_at,
                          input logic load_on_final);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 32'(i);
            in_last  = (i == last_at);
            if (i == n - 1) load_ok = load_on_final;
            #1;
            chk("in_ready_word", 256'(in_ready), 256'(1));
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_and_check(input string tag, input logic expect_swap);
        load_ok = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_ok = 1'b0;
        chk({tag, ".nonce_clear_pulse"}, 256'(nonce_clear), 256'(expect_swap));
        check_active(tag);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".nonce_clear_after"}, 256'(nonce_clear), 256'(0));
        check_active({tag, "_hold"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{base: 32'h0000_0000, gap: 2, exp_id: 4'd1};
        vecs[1] = '{base: 32'h0000_1000, gap: 0, exp_id: 4'd2};
        vecs[2] = '{base: 32'hA5A5_0000, gap: 5, exp_id: 4'd3};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; load_ok = 1'b0;
        exp_mid = '0; exp_tail = '0; exp_id = '0; exp_valid = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst.in_ready", 256'(in_ready), 256'(0));
        check_active("rst");
        chk("rst.nonce_clear", 256'(nonce_clear), 256'(0));
        chk("rst.err_short", 256'(err_short), 256'(0));
        chk("rst.err_long", 256'(err_long), 256'(0));
        rst = 1'b0;
        #1;
        chk("rst.in_ready_after", 256'(in_ready), 256'(1));
        @(negedge clk);

        // early last on word 4
        stream(32'h0000_0100, 5, 4, 1'b0);
        chk("short.err_short", 256'(err_short), 256'(1));
        chk("short.err_long", 256'(err_long), 256'(0));
        chk("short.in_ready", 256'(in_ready), 256'(1));
        check_active("short");

        // clean jobs from the table
        foreach (vecs[v]) begin
            stream(vecs[v].base, 11, 10, 1'b0);
            chk("vec.in_ready_pending", 256'(in_ready), 256'(0));
            for (int g = 0; g < vecs[v].gap; g++) begin
                chk("vec.nonce_clear_idle", 256'(nonce_clear), 256'(0));
                check_active("vec_wait");
                @(posedge clk);
                @(negedge clk);
            end
            exp_mid = mid_of(vecs[v].base); exp_tail = tail_of(vecs[v].base);
            exp_id = vecs[v].exp_id; exp_valid = 1'b1;
            pulse_and_check("vec", 1'b1);
        end

        // load_ok in FILL is ignored
        pulse_and_check("fill_load", 1'b0);

        // missing last: 11 words without in_last, then 2 extra, last on second
        stream(32'hBEEF_0000, 13, 12, 1'b0);
        chk("long.err_long", 256'(err_long), 256'(1));
        chk("long.err_short", 256'(err_short), 256'(1));
        chk("long.in_ready", 256'(in_ready), 256'(1));
        check_active("long");
        stream(32'h0000_2000, 11, 10, 1'b0);
        @(posedge clk); @(negedge clk);
        exp_mid = mid_of(32'h0000_2000); exp_tail = tail_of(32'h0000_2000); exp_id = 4'd4;
        pulse_and_check("after_long", 1'b1);

        // backpressure: job B held for 20 cycles with a word waiting
        stream(32'h0000_3000, 11, 10, 1'b0);
        in_valid = 1'b1; in_data = 32'hDEAD_DEAD;
        for (int c = 0; c < 20; c++) begin
            #1;
            chk("bp.in_ready", 256'(in_ready), 256'(0));
            check_active("bp");
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        exp_mid = mid_of(32'h0000_3000); exp_tail = tail_of(32'h0000_3000); exp_id = 4'd5;
        pulse_and_check("bp_swap", 1'b1);

        // load_ok coincident with final-word accept, then one cycle later
        stream(32'h0000_4000, 11, 10, 1'b1);
        chk("same.nonce_clear", 256'(nonce_clear), 256'(0));
        chk("same.in_ready", 256'(in_ready), 256'(0));
        check_active("same_noswap");
        @(posedge clk);
        @(negedge clk);
        load_ok = 1'b0;
        exp_mid = mid_of(32'h0000_4000); exp_tail = tail_of(32'h0000_4000); exp_id = 4'd6;
        chk("same.nonce_clear_swap", 256'(nonce_clear), 256'(1));
        check_active("same_swap");
        @(posedge clk); @(negedge clk);
        chk("same.nonce_clear_after", 256'(nonce_clear), 256'(0));

        // ten more jobs: sixteen swaps in total wrap work_id to 0
        for (int j = 0; j < 10; j++) begin
            stream(32'h1000_0000 + 32'(j) * 32'h100, 11, 10, 1'b0);
            exp_mid = mid_of(32'h1000_0000 + 32'(j) * 32'h100);
            exp_tail = tail_of(32'h1000_0000 + 32'(j) * 32'h100);
            exp_id = exp_id + 4'd1;
            pulse_and_check("wrap", 1'b1);
        end
        chk("wrap.work_id_zero", 256'(work_id), 256'(0));

        // reset mid-fill at word 5
        stream(32'h0000_6000, 5, -1, 1'b0);
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h0000_6005;
        #1;
        chk("rst2.in_ready_during", 256'(in_ready), 256'(0));
        @(posedge clk);
        @(negedge clk);
        exp_mid = '0; exp_tail = '0; exp_id = '0; exp_valid = 1'b0;
        chk("rst2.in_ready_held", 256'(in_ready), 256'(0));
        check_active("rst2");
        chk("rst2.nonce_clear", 256'(nonce_clear), 256'(0));
        chk("rst2.err_short", 256'(err_short), 256'(0));
        chk("rst2.err_long", 256'(err_long), 256'(0));
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst2.in_ready_after", 256'(in_ready), 256'(1));
        @(negedge clk);
        stream(32'h0000_7000, 11, 10, 1'b0);
        exp_mid = mid_of(32'h0000_7000); exp_tail = tail_of(32'h0000_7000);
        exp_id = 4'd1; exp_valid = 1'b1;
        pulse_and_check("post_rst", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha256_work_loader.md
Name: sha256_work_loader

Overview:
- Upstream feeder for the miner top level. Accepts a new mining job over a 32-bit valid/ready word stream.
- A job is 8 midstate words plus 3 block-tail words (merkle tail, time, bits). The block assembles the job in a shadow buffer.
- The shadow buffer is swapped into the active job registers only at a hash-pipeline load boundary. The swap emits a one-cycle nonce_clear so the miner restarts nonce counting from 0 on the new job.

Parameters:
- MID_WORDS, 8, number of 32-bit midstate words per job.
- TAIL_WORDS, 3, number of 32-bit block-tail words per job.
- ID_W, 4, width of the job identifier counter.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  word-stream valid.
- in_ready  out  1  word-stream ready.
- in_data  in  32  job word.
- in_last  in  1  marks the final word of a job.
- load_ok  in  1  miner boundary strobe: high in cycles where the miner's next cnt is 0, i.e. feedback_next == 0.
- midstate_out  out  256  active midstate, fed to the first transform's rx_state.
- tail_out  out  96  active block tail, placed above the nonce in the data word.
- work_valid  out  1  high once any job has been loaded.
- work_id  out  ID_W  increments on every swap; wraps modulo 2^ID_W.
- nonce_clear  out  1  one-cycle pulse coincident with a swap.
- err_short  out  1  sticky: in_last arrived before word MID_WORDS+TAIL_WORDS-1.
- err_long  out  1  sticky: the final word arrived without in_last.

Behaviour:
- A word is accepted in a cycle where in_valid && in_ready.
- Word index k (0..10) is held in a 4-bit counter.
  - k < 8 writes shadow_mid[32k +: 32].
  - k ≥ 8 writes shadow_tail[32(k-8) +: 32].
- States: FILL, PENDING, DROP.
- FILL:
  - in_ready = 1.
  - Accepting k == 10 with in_last → PENDING; k := 0.
  - Accepting k < 10 with in_last → err_short := 1; discard partial; k := 0; stay FILL.
  - Accepting k == 10 without in_last → err_long := 1; k := 0; → DROP.
- DROP:
  - in_ready = 1.
  - Words are consumed and discarded.
  - Accepting a word with in_last → FILL.
- PENDING:
  - in_ready = 0.
  - On load_ok: active regs := shadow; work_id += 1; work_valid := 1; nonce_clear := 1 for one cycle; → FILL.
- Latency: final word accepted at cycle t → PENDING from t+1. The earliest swap is on load_ok at t+1, with outputs visible at t+2.
- load_ok in the same cycle as final-word acceptance does not swap. The swap waits for the next load_ok.
- A load_ok while in FILL or DROP is ignored; active outputs are held.
- nonce_clear is registered and asserted in the same cycle midstate_out/tail_out first show the new job.
- work_id wraps from 2^ID_W-1 to 0 with no flag.
- Reset values:
  - midstate_out = 0, tail_out = 0, work_valid = 0, work_id = 0.
  - nonce_clear = 0, err_short = 0, err_long = 0.
  - in_ready = 0 while rst is high; state := FILL and k := 0.
  - Reset mid-fill or in PENDING discards the shadow job. Active outputs return to 0.
- Errors clear only on rst. An error never alters the active job.

Decomposition:
- Shared package mining_pkg holds:
  - MID_WORDS, TAIL_WORDS, JOB_WORDS = 11.
  - The job-word index encoding.
  - The state enum {FILL, PENDING, DROP}.
- One sub-module is natural: job_shadow_buf, an indexed 32-bit word writer producing the 256-bit and 96-bit shadow vectors.
- The FSM, swap logic and counters stay in the top.

Test Plan:
- Basic load:
  - Stimulus: stream words 0x00000000..0x0000000A with in_last on word 10; load_ok pulses 3 cycles after acceptance.
  - Response: midstate_out = {0x7,...,0x0}; tail_out = {0xA,0x9,0x8}; work_id = 1; work_valid = 1; nonce_clear high exactly one cycle, coincident with the new outputs.
- Early last:
  - Stimulus: in_last on word 4.
  - Response: err_short = 1; outputs unchanged (0); a following clean 11-word job loads with work_id = 1.
- Missing last:
  - Stimulus: 11 words with no in_last, then 2 extra words with in_last on the second.
  - Response: err_long = 1; extra words consumed (in_ready = 1); the next clean job loads normally.
- Backpressure and held job:
  - Stimulus: job A loaded; job B completed while load_ok is held low for 20 cycles.
  - Response: in_ready = 0 throughout; outputs still show A; the swap to B occurs on the first load_ok, with work_id = 2.
- Same-cycle and ignored load_ok:
  - Stimulus: load_ok coincident with the final-word accept, then again 1 cycle later.
  - Response: no swap at the first strobe; swap at the second.
- Wrap and reset:
  - Stimulus: 16 jobs with ID_W = 4, giving work_id = 0; then assert rst mid-fill at word 5.
  - Response: all outputs 0; in_ready = 0 during rst and 1 the cycle after; the next job starts at index 0 with work_id = 1.
